otp_ctrl_lci_resp: RTL and testbench
====================================

// Module: otp_ctrl_lci_resp
// PURPOSE
//  OTP-side responder for the life cycle programming interface: accepts the
//  single-word req/gnt/rvalid transactions the LCI initiator issues.
//  Holds an on-chip model of the LC partition as NumWords 16-bit OTP words.
//  Enforces write-once semantics and returns prim_otp error codes.
//  Used as the OTP-macro stand-in for LCI integration benches and FPGA
//  bring-up.
// PARAMETERS
//  NumWords    44   LC partition size in 16-bit OTP words
//  BaseAddr    0    first halfword address of the partition (OtpAddrWidth bits)
//  RspLatency  2    cycles from grant to rvalid (1..15)
// PORTS
//  clk_i         in   1    clock
//  rst_i         in   1    synchronous, active-high reset; one clock only
//  wipe_i        in   1    zero the whole array; honoured only in IdleSt
//  otp_req_i     in   1    request valid
//  otp_cmd_i     in   cmd_e  prim_otp_pkg::Read / Write; other values -> MacroError
//  otp_size_i    in   OtpSizeWidth   must be 0 (16-bit access), else MacroError
//  otp_wdata_i   in   OtpIfWidth     write data; bits [15:0] are used
//  otp_addr_i    in   OtpAddrWidth   halfword address
//  otp_gnt_o     out  1    request accepted (combinational, same cycle)
//  otp_rvalid_o  out  1    one-cycle response strobe
//  otp_rdata_o   out  ScrmblBlockWidth  read word zero-extended; 0 for writes
//  otp_err_o     out  err_e  0 NoError, 1 MacroError, 4 MacroWriteBlankingError
//  fsm_err_o     out  1    pulsed when the FSM decodes an invalid state
// BEHAVIOUR
//  - Reset values: gnt=0, rvalid=0, rdata=0, err=NoError, fsm_err=0, state=IdleSt.
//  - Reset does not clear the array; the array is non-volatile.
//  - Only wipe_i clears it: one cycle, all words become 0.
//  - FSM states are sparse 6-bit (min Hamming distance 3): IdleSt, BusySt, RspSt, ErrorSt.
//  - IdleSt:
//    - otp_gnt_o = otp_req_i && !wipe_i.
//    - On grant, latch cmd/size/addr/wdata[15:0], load the latency counter
//      with RspLatency-1, then go to BusySt. If RspLatency==1, go directly to RspSt.
//    - If wipe_i and req are both high, the wipe wins and no grant is given.
//  - BusySt: decrement the counter. When it reaches 0, go to RspSt.
//    - Requests are not granted while busy; one transaction is outstanding at most.
//  - RspSt: assert rvalid for exactly one cycle, perform the access, return to IdleSt.
//    - Grant = 1 cycle; rvalid follows RspLatency cycles later.
//    - The next grant is possible in the cycle after rvalid.
//  - Address check: idx = addr - BaseAddr.
//    - addr < BaseAddr or idx >= NumWords -> MacroError, no array change, rdata=0.
//  - Read: rdata = {'0, mem[idx]}, err = NoError.
//  - Write:
//    - If mem[idx] & ~wdata != 0, err = MacroWriteBlankingError.
//    - In every write case, mem[idx] <= mem[idx] | wdata; bits only ever go 0->1.
//    - Rewriting identical or superset data returns NoError.
//  - Precedence of errors: bad cmd/size/addr (MacroError) over blanking.
//  - ErrorSt: terminal. No grants; answers nothing. Exited only by rst_i.
//    - An invalid state encoding goes to ErrorSt and pulses fsm_err_o.
//  - rst_i during BusySt/RspSt drops the pending access.
//    - No array update, no rvalid.
// STRUCTURE
//  - Use err_e, cmd_e, and the OtpAddrWidth/OtpIfWidth/OtpSizeWidth constants
//    from prim_otp_pkg / otp_ctrl_pkg.
//  - Add the state_e encoding to otp_ctrl_pkg as lci_resp_state_e.
//  - One sub-module, otp_ctrl_lci_resp_mem: the flop array with write-OR,
//    blank check and wipe. Comb read, sync write, no reset.
// TESTING
//  - wipe; read every word -> rvalid RspLatency cycles after gnt, rdata=0, err=0.
//  - Write 0x00F0 then 0x00FF to word 3 -> both NoError; read gives 0x00FF.
//  - Write 0x000F to word 3 after 0x00FF -> err=4; read still gives 0x00FF.
//  - addr=BaseAddr+NumWords, or size=1 -> err=1, array unchanged.
//  - req held high back-to-back -> gnt only in IdleSt; one rvalid per gnt.
//  - rst_i in BusySt -> no rvalid, array unchanged.
//  - Force an illegal state -> fsm_err_o pulses, gnt stuck at 0 until rst_i.

Source files
------------

// File: rtl/otp_ctrl_lci_resp_pkg.sv
// Shared types and constants for the LCI responder: OTP macro command and
// error codes, interface widths and the sparse FSM state encoding.
package otp_ctrl_lci_resp_pkg;

  localparam int OtpWidth         = 16;
  localparam int OtpSizeWidth     = 2;
  localparam int OtpIfWidth       = (1 << OtpSizeWidth) * OtpWidth;
  localparam int OtpAddrWidth     = 10;
  localparam int OtpCmdWidth      = 3;
  localparam int ScrmblBlockWidth = 64;
  localparam int OtpCntWidth      = 4;

  typedef enum logic [OtpCmdWidth-1:0] {
    Read     = 3'b000,
    Write    = 3'b001,
    ReadRaw  = 3'b010,
    WriteRaw = 3'b011,
    Zeroize  = 3'b100
  } cmd_e;

  typedef enum logic [2:0] {
    NoError                 = 3'd0,
    MacroError              = 3'd1,
    MacroEccCorrError       = 3'd2,
    MacroEccUncorrError     = 3'd3,
    MacroWriteBlankingError = 3'd4
  } err_e;

  // Pairwise Hamming distance >= 3 so a single flipped bit never lands on a legal state.
  typedef logic [5:0] lci_resp_state_e;
  localparam lci_resp_state_e IdleSt  = 6'b101001;
  localparam lci_resp_state_e BusySt  = 6'b010011;
  localparam lci_resp_state_e RspSt   = 6'b110110;
  localparam lci_resp_state_e ErrorSt = 6'b001100;

  function automatic logic blank_violation(input logic [OtpWidth-1:0] cur,
                                           input logic [OtpWidth-1:0] wdata);
    return |(cur & ~wdata);
  endfunction

endpackage

// File: rtl/otp_ctrl_lci_resp_if.sv
// Single-word req/gnt/rvalid bus between the LCI initiator and the OTP side.
interface otp_ctrl_lci_resp_if;
  import otp_ctrl_lci_resp_pkg::*;

  logic                        otp_req_i;
  cmd_e                        otp_cmd_i;
  logic [OtpSizeWidth-1:0]     otp_size_i;
  logic [OtpIfWidth-1:0]       otp_wdata_i;
  logic [OtpAddrWidth-1:0]     otp_addr_i;
  logic                        otp_gnt_o;
  logic                        otp_rvalid_o;
  logic [ScrmblBlockWidth-1:0] otp_rdata_o;
  err_e                        otp_err_o;

  modport master (
    output otp_req_i, otp_cmd_i, otp_size_i, otp_wdata_i, otp_addr_i,
    input  otp_gnt_o, otp_rvalid_o, otp_rdata_o, otp_err_o
  );

  modport slave (
    input  otp_req_i, otp_cmd_i, otp_size_i, otp_wdata_i, otp_addr_i,
    output otp_gnt_o, otp_rvalid_o, otp_rdata_o, otp_err_o
  );

endinterface

// File: rtl/otp_ctrl_lci_resp_mem.sv
// Non-volatile LC partition model: flop array, OR-only writes, blank check
// against the addressed word, and a one-cycle wipe. No reset by design.
module otp_ctrl_lci_resp_mem
  import otp_ctrl_lci_resp_pkg::*;
#(
  parameter int NumWords = 44,
  parameter int IdxW     = $clog2(NumWords)
) (
  input  logic                clk_i,
  input  logic                i_wipe,
  input  logic                i_we,
  input  logic [IdxW-1:0]     i_idx,
  input  logic [OtpWidth-1:0] i_wdata,
  output logic [OtpWidth-1:0] o_rdata,
  output logic                o_blank_err
);

  localparam logic [IdxW:0] NumWordsW = (IdxW+1)'(NumWords);

  logic [OtpWidth-1:0] w_words [NumWords];
  logic                w_idx_ok;
  logic [OtpWidth-1:0] w_rdata;

  generate
    for (genvar gi = 0; gi < NumWords; gi++) begin : g_word
      logic [OtpWidth-1:0] r_word;

      always_ff @(posedge clk_i) begin
        if (i_wipe) begin
          r_word <= '0;
        end else if (i_we && (i_idx == IdxW'(gi))) begin
          r_word <= r_word | i_wdata;
        end
      end

      assign w_words[gi] = r_word;
    end
  endgenerate

  assign w_idx_ok    = ({1'b0, i_idx} < NumWordsW);
  assign w_rdata     = w_idx_ok ? w_words[i_idx] : '0;
  assign o_rdata     = w_rdata;
  assign o_blank_err = blank_violation(w_rdata, i_wdata);

endmodule

// File: rtl/otp_ctrl_lci_resp.sv
// OTP-side responder for the life cycle programming interface: one outstanding
// access, fixed grant-to-rvalid latency, write-once LC partition model.
module otp_ctrl_lci_resp
  import otp_ctrl_lci_resp_pkg::*;
#(
  parameter int                      NumWords   = 44,
  parameter logic [OtpAddrWidth-1:0] BaseAddr   = '0,
  parameter int                      RspLatency = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wipe_i,
  otp_ctrl_lci_resp_if.slave   otp_bus,
  output logic                 fsm_err_o
);

  localparam int                      IdxW    = $clog2(NumWords);
  localparam logic [OtpCntWidth-1:0]  CntInit = OtpCntWidth'(RspLatency - 1);
  localparam logic [OtpAddrWidth:0]   AddrLo  = {1'b0, BaseAddr};
  localparam logic [OtpAddrWidth:0]   AddrHi  = AddrLo + (OtpAddrWidth+1)'(NumWords);

  lci_resp_state_e         r_state;
  logic [OtpCntWidth-1:0]  r_cnt;
  cmd_e                    r_cmd;
  logic [OtpSizeWidth-1:0] r_size;
  logic [OtpAddrWidth-1:0] r_addr;
  logic [OtpWidth-1:0]     r_wdata;

  lci_resp_state_e         w_state_next;
  logic [OtpCntWidth-1:0]  w_cnt_next;
  logic                    w_fsm_err;
  logic                    w_gnt;
  logic                    w_rsp;
  logic                    w_wipe;
  logic                    w_cmd_ok;
  logic                    w_size_ok;
  logic                    w_addr_ok;
  logic                    w_macro_err;
  logic                    w_is_read;
  logic                    w_is_write;
  logic                    w_we;
  logic [IdxW-1:0]         w_idx;
  logic [OtpWidth-1:0]     w_mem_rdata;
  logic                    w_blank_err;
  err_e                    w_err;
  logic                    w_unused_wdata_hi;

  // Only one access in flight, so grants are limited to IdleSt; wipe beats req.
  assign w_gnt  = (r_state == IdleSt) && otp_bus.otp_req_i && !wipe_i && !rst_i;
  assign w_wipe = (r_state == IdleSt) && wipe_i && !rst_i;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_fsm_err    = 1'b0;
    case (r_state)
      IdleSt: begin
        if (w_gnt) begin
          w_cnt_next   = CntInit;
          w_state_next = (RspLatency == 1) ? RspSt : BusySt;
        end
      end
      BusySt: begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt <= OtpCntWidth'(1)) begin
          w_state_next = RspSt;
        end
      end
      RspSt: begin
        w_state_next = IdleSt;
      end
      ErrorSt: begin
        w_state_next = ErrorSt;
      end
      default: begin
        w_state_next = ErrorSt;
        w_fsm_err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IdleSt;
      r_cnt   <= '0;
      r_cmd   <= Read;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_gnt) begin
        r_cmd   <= otp_bus.otp_cmd_i;
        r_size  <= otp_bus.otp_size_i;
        r_addr  <= otp_bus.otp_addr_i;
        r_wdata <= otp_bus.otp_wdata_i[OtpWidth-1:0];
      end
    end
  end

  assign w_unused_wdata_hi = ^otp_bus.otp_wdata_i[OtpIfWidth-1:OtpWidth];

  // A reset landing on the response cycle drops the access entirely.
  assign w_rsp       = (r_state == RspSt) && !rst_i;
  assign w_is_read   = (r_cmd == Read);
  assign w_is_write  = (r_cmd == Write);
  assign w_cmd_ok    = w_is_read || w_is_write;
  assign w_size_ok   = (r_size == '0);
  assign w_addr_ok   = ({1'b0, r_addr} >= AddrLo) && ({1'b0, r_addr} < AddrHi);
  assign w_macro_err = !(w_cmd_ok && w_size_ok && w_addr_ok);
  assign w_idx       = IdxW'(r_addr - BaseAddr);
  assign w_we        = w_rsp && !w_macro_err && w_is_write;

  otp_ctrl_lci_resp_mem #(
    .NumWords (NumWords),
    .IdxW     (IdxW)
  ) u_mem (
    .clk_i       (clk_i),
    .i_wipe      (w_wipe),
    .i_we        (w_we),
    .i_idx       (w_idx),
    .i_wdata     (r_wdata),
    .o_rdata     (w_mem_rdata),
    .o_blank_err (w_blank_err)
  );

  // Structural errors take precedence over the blank check.
  always_comb begin
    w_err = NoError;
    if (w_rsp) begin
      if (w_macro_err) begin
        w_err = MacroError;
      end else if (w_is_write && w_blank_err) begin
        w_err = MacroWriteBlankingError;
      end
    end
  end

  assign otp_bus.otp_gnt_o    = w_gnt;
  assign otp_bus.otp_rvalid_o = w_rsp;
  assign otp_bus.otp_rdata_o  = (w_rsp && !w_macro_err && w_is_read) ?
                                {{(ScrmblBlockWidth-OtpWidth){1'b0}}, w_mem_rdata} : '0;
  assign otp_bus.otp_err_o    = w_err;
  assign fsm_err_o            = w_fsm_err;

endmodule

// File: tb/tb_otp_ctrl_lci_resp.sv
// Directed bench for the LCI responder: one task per scenario with
// hand-computed expectations and a single summary line.
module tb_otp_ctrl_lci_resp;
  import otp_ctrl_lci_resp_pkg::*;

  localparam int NW  = 44;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic wipe;
  logic fsm_err;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  otp_ctrl_lci_resp_if bus ();

  otp_ctrl_lci_resp #(
    .NumWords   (NW),
    .BaseAddr   (10'd0),
    .RspLatency (LAT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wipe_i    (wipe),
    .otp_bus   (bus),
    .fsm_err_o (fsm_err)
  );

  // Issues one request at a negedge and waits (bounded) for its rvalid.
  task automatic txn(input cmd_e cmd, input logic [1:0] size, input logic [9:0] addr,
                     input logic [15:0] wdata, output logic [63:0] rdata,
                     output logic [2:0] err, output int lat, output logic granted);
    @(negedge clk);
    bus.otp_req_i   = 1'b1;
    bus.otp_cmd_i   = cmd;
    bus.otp_size_i  = size;
    bus.otp_addr_i  = addr;
    bus.otp_wdata_i = {48'hA5A5_A5A5_A5A5, wdata};
    #1 granted = bus.otp_gnt_o;
    @(negedge clk);
    bus.otp_req_i = 1'b0;
    lat   = -1;
    rdata = '0;
    err   = '0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (bus.otp_rvalid_o === 1'b1) begin
        lat   = c;
        rdata = bus.otp_rdata_o;
        err   = bus.otp_err_o;
        break;
      end
      @(negedge clk);
    end
    $display("txn cmd=%0d size=%0d addr=%0d wdata=%h gnt=%b lat=%0d err=%0d rdata=%h",
             cmd, size, addr, wdata, granted, lat, err, rdata);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wipe = 1'b0;
    bus.otp_req_i = 1'b1;
    bus.otp_cmd_i = Read;
    bus.otp_size_i = '0;
    bus.otp_addr_i = '0;
    bus.otp_wdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.otp_gnt_o !== 1'b0) begin n_bad++; $display("FAIL reset_gnt_in_rst: got %b want 0", bus.otp_gnt_o); end
    rst = 1'b0;
    bus.otp_req_i = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.otp_gnt_o !== 1'b0) begin n_bad++; $display("FAIL reset_gnt: got %b want 0", bus.otp_gnt_o); end
    n_cmp++; if (bus.otp_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", bus.otp_rvalid_o); end
    n_cmp++; if (bus.otp_rdata_o !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.otp_rdata_o); end
    n_cmp++; if (bus.otp_err_o !== NoError) begin n_bad++; $display("FAIL reset_err: got %0d want 0", bus.otp_err_o); end
    n_cmp++; if (fsm_err !== 1'b0) begin n_bad++; $display("FAIL reset_fsm_err: got %b want 0", fsm_err); end
  endtask

  task automatic test_wipe();
    logic [63:0] rd;
    logic [2:0]  er;
    int          lat;
    logic        g;
    @(negedge clk);
    wipe = 1'b1;
    bus.otp_req_i = 1'b1;
    bus.otp_cmd_i = Read;
    bus.otp_addr_i = 10'd0;
    #1;
    n_cmp++; if (bus.otp_gnt_o !== 1'b0) begin n_bad++; $display("FAIL wipe_beats_req: got gnt=%b want 0", bus.otp_gnt_o); end
    @(negedge clk);
    wipe = 1'b0;
    bus.otp_req_i = 1'b0;
    #1;
    n_cmp++; if (bus.otp_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL wipe_no_rsp: got rvalid=%b want 0", bus.otp_rvalid_o); end
    for (int a = 0; a < NW; a++) begin
      txn(Read, 2'd0, 10'(a), 16'h0, rd, er, lat, g);
      n_cmp++; if (g !== 1'b1) begin n_bad++; $display("FAIL wipe_gnt[%0d]: got %b want 1", a, g); end
      n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL wipe_lat[%0d]: got %0d want %0d", a, lat, LAT); end
      n_cmp++; if (rd !== 64'h0) begin n_bad++; $display("FAIL wipe_rdata[%0d]: got %h want 0", a, rd); end
      n_cmp++; if (er !== 3'd0) begin n_bad++; $display("FAIL wipe_err[%0d]: got %0d want 0", a, er); end
    end
  endtask

  task automatic test_write_or();
    logic [63:0] rd;
    logic [2:0]  er;
    int          lat;
    logic        g;
    txn(Write, 2'd0, 10'd3, 16'h00F0, rd, er, lat, g);
    n_cmp++; if (er !== 3'd0 || lat != LAT) begin n_bad++; $display("FAIL wr_f0: got err=%0d lat=%0d want 0/%0d", er, lat, LAT); end
    n_cmp++; if (rd !== 64'h0) begin n_bad++; $display("FAIL wr_f0_rdata: got %h want 0", rd); end
    txn(Write, 2'd0, 10'd3, 16'h00FF, rd, er, lat, g);
    n_cmp++; if (er !== 3'd0) begin n_bad++; $display("FAIL wr_ff: got err=%0d want 0", er); end
    txn(Read, 2'd0, 10'd3, 16'h0, rd, er, lat, g);
    n_cmp++; if (rd !== 64'h00FF || er !== 3'd0) begin n_bad++; $display("FAIL rd_w3: got %h/%0d want 00ff/0", rd, er); end
  endtask

  task automatic test_blanking();
    logic [63:0] rd;
    logic [2:0]  er;
    int          lat;
    logic        g;
    txn(Write, 2'd0, 10'd3, 16'h000F, rd, er, lat, g);
    n_cmp++; if (er !== 3'd4) begin n_bad++; $display("FAIL blank_0f: got err=%0d want 4", er); end
    txn(Read, 2'd0, 10'd3, 16'h0, rd, er, lat, g);
    n_cmp++; if (rd !== 64'h00FF) begin n_bad++; $display("FAIL blank_rd_w3: got %h want 00ff", rd); end
    txn(Write, 2'd0, 10'd4, 16'h00FF, rd, er, lat, g);
    n_cmp++; if (er !== 3'd0) begin n_bad++; $display("FAIL blank_w4_init: got err=%0d want 0", er); end
    txn(Write, 2'd0, 10'd4, 16'h0F0F, rd, er, lat, g);
    n_cmp++; if (er !== 3'd4) begin n_bad++; $display("FAIL blank_w4_0f0f: got err=%0d want 4", er); end
    txn(Read, 2'd0, 10'd4, 16'h0, rd, er, lat, g);
    n_cmp++; if (rd !== 64'h0FFF) begin n_bad++; $display("FAIL blank_or_w4: got %h want 0fff", rd); end
  endtask

  task automatic test_macro_err();
    logic [63:0] rd;
    logic [2:0]  er;
    int          lat;
    logic        g;
    txn(Write, 2'd0, 10'(NW), 16'hFFFF, rd, er, lat, g);
    n_cmp++; if (er !== 3'd1 || lat != LAT) begin n_bad++; $display("FAIL oob_wr: got err=%0d lat=%0d want 1/%0d", er, lat, LAT); end
    txn(Read, 2'd0, 10'(NW), 16'h0, rd, er, lat, g);
    n_cmp++; if (er !== 3'd1 || rd !== 64'h0) begin n_bad++; $display("FAIL oob_rd: got %h/%0d want 0/1", rd, er); end
    txn(Read, 2'd0, 10'h3FF, 16'h0, rd, er, lat, g);
    n_cmp++; if (er !== 3'd1) begin n_bad++; $display("FAIL oob_max: got err=%0d want 1", er); end
    txn(Write, 2'd1, 10'd5, 16'h1234, rd, er, lat, g);
    n_cmp++; if (er !== 3'd1) begin n_bad++; $display("FAIL size_wr: got err=%0d want 1", er); end
    txn(Read, 2'd0, 10'd5, 16'h0, rd, er, lat, g);
    n_cmp++; if (rd !== 64'h0 || er !== 3'd0) begin n_bad++; $display("FAIL size_wr_nochg: got %h/%0d want 0/0", rd, er); end
    txn(Read, 2'd1, 10'd3, 16'h0, rd, er, lat, g);
    n_cmp++; if (rd !== 64'h0 || er !== 3'd1) begin n_bad++; $display("FAIL size_rd: got %h/%0d want 0/1", rd, er); end
    txn(ReadRaw, 2'd0, 10'd3, 16'h0, rd, er, lat, g);
    n_cmp++; if (er !== 3'd1) begin n_bad++; $display("FAIL bad_cmd: got err=%0d want 1", er); end
    txn(Write, 2'd1, 10'd3, 16'h0000, rd, er, lat, g);
    n_cmp++; if (er !== 3'd1) begin n_bad++; $display("FAIL err_prec: got err=%0d want 1", er); end
    txn(Read, 2'd0, 10'd3, 16'h0, rd, er, lat, g);
    n_cmp++; if (rd !== 64'h00FF) begin n_bad++; $display("FAIL prec_nochg: got %h want 00ff", rd); end
    txn(Write, 2'd0, 10'(NW-1), 16'h8001, rd, er, lat, g);
    n_cmp++; if (er !== 3'd0) begin n_bad++; $display("FAIL last_wr: got err=%0d want 0", er); end
    txn(Read, 2'd0, 10'(NW-1), 16'h0, rd, er, lat, g);
    n_cmp++; if (rd !== 64'h8001) begin n_bad++; $display("FAIL last_rd: got %h want 8001", rd); end
  endtask

  task automatic test_back_to_back();
    int   ng = 0;
    int   nv = 0;
    logic g;
    logic v;
    logic exp_g;
    logic exp_v;
    @(negedge clk);
    bus.otp_req_i = 1'b1;
    bus.otp_cmd_i = Read;
    bus.otp_size_i = 2'd0;
    bus.otp_addr_i = 10'd3;
    // With latency 2 each access spans Idle, Busy, Rsp: grant every third cycle.
    for (int i = 0; i < 12; i++) begin
      #1;
      g = bus.otp_gnt_o;
      v = bus.otp_rvalid_o;
      exp_g = (i % 3 == 0);
      exp_v = (i % 3 == 2);
      n_cmp++; if (g !== exp_g) begin n_bad++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, g, exp_g); end
      n_cmp++; if (v !== exp_v) begin n_bad++; $display("FAIL b2b_rvalid[%0d]: got %b want %b", i, v, exp_v); end
      if (exp_v) begin
        n_cmp++; if (bus.otp_rdata_o !== 64'h00FF) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %h want 00ff", i, bus.otp_rdata_o); end
      end
      if (g === 1'b1) ng++;
      if (v === 1'b1) nv++;
      @(negedge clk);
    end
    bus.otp_req_i = 1'b0;
    $display("txn back_to_back grants=%0d responses=%0d", ng, nv);
    n_cmp++; if (ng != 4 || nv != 4) begin n_bad++; $display("FAIL b2b_counts: got %0d/%0d want 4/4", ng, nv); end
  endtask

  task automatic test_reset_busy();
    logic [63:0] rd;
    logic [2:0]  er;
    int          lat;
    logic        g;
    int          seen = 0;
    @(negedge clk);
    bus.otp_req_i = 1'b1;
    bus.otp_cmd_i = Write;
    bus.otp_size_i = 2'd0;
    bus.otp_addr_i = 10'd6;
    bus.otp_wdata_i = 64'hABCD;
    #1;
    n_cmp++; if (bus.otp_gnt_o !== 1'b1) begin n_bad++; $display("FAIL rstb_gnt: got %b want 1", bus.otp_gnt_o); end
    @(negedge clk);
    bus.otp_req_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.otp_rvalid_o !== 1'b0) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rstb_rvalid: got %0d strobes want 0", seen); end
    txn(Read, 2'd0, 10'd6, 16'h0, rd, er, lat, g);
    n_cmp++; if (rd !== 64'h0 || lat != LAT) begin n_bad++; $display("FAIL rstb_nochg: got %h lat=%0d want 0/%0d", rd, lat, LAT); end
    @(negedge clk);
    bus.otp_req_i = 1'b1;
    bus.otp_cmd_i = Write;
    bus.otp_addr_i = 10'd7;
    bus.otp_wdata_i = 64'h5555;
    @(negedge clk);
    bus.otp_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.otp_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rstr_rvalid: got %b want 0", bus.otp_rvalid_o); end
    @(negedge clk);
    rst = 1'b0;
    txn(Read, 2'd0, 10'd7, 16'h0, rd, er, lat, g);
    n_cmp++; if (rd !== 64'h0) begin n_bad++; $display("FAIL rstr_nochg: got %h want 0", rd); end
  endtask

  task automatic test_fsm_err();
    logic [63:0] rd;
    logic [2:0]  er;
    int          lat;
    logic        g;
    @(negedge clk);
    bus.otp_req_i = 1'b1;
    bus.otp_cmd_i = Read;
    bus.otp_size_i = 2'd0;
    bus.otp_addr_i = 10'd3;
    force dut.r_state = 6'b000000;
    #1;
    n_cmp++; if (fsm_err !== 1'b1) begin n_bad++; $display("FAIL fsm_err_pulse: got %b want 1", fsm_err); end
    n_cmp++; if (bus.otp_gnt_o !== 1'b0) begin n_bad++; $display("FAIL fsm_err_gnt: got %b want 0", bus.otp_gnt_o); end
    @(posedge clk);
    #1 release dut.r_state;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus.otp_gnt_o !== 1'b0 || bus.otp_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL errst_stuck[%0d]: got gnt=%b rvalid=%b want 0/0", i, bus.otp_gnt_o, bus.otp_rvalid_o); end
      n_cmp++; if (fsm_err !== 1'b0) begin n_bad++; $display("FAIL errst_fsm_err[%0d]: got %b want 0", i, fsm_err); end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.otp_gnt_o !== 1'b1) begin n_bad++; $display("FAIL errst_recover: got gnt=%b want 1", bus.otp_gnt_o); end
    bus.otp_req_i = 1'b0;
    txn(Read, 2'd0, 10'd3, 16'h0, rd, er, lat, g);
    n_cmp++; if (rd !== 64'h00FF || er !== 3'd0) begin n_bad++; $display("FAIL nonvolatile: got %h/%0d want 00ff/0", rd, er); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wipe();
    test_write_or();
    test_blanking();
    test_macro_err();
    test_back_to_back();
    test_reset_busy();
    test_fsm_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
